// File: rtl/lix_pkg.sv
// Shared constants and helpers for the lix elastic pipeline.
package lix_pkg;

    localparam int unsigned LIX_PIPE_DMAX = 16;

    // Width of an occupancy count that must represent 0..d inclusive.
    function automatic int unsigned lix_cnt_w(input int unsigned d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/lix_pipe_if.sv
// Upstream/downstream valid-ready handshake bundle for lix_pipe.
interface lix_pipe_if #(
    parameter int unsigned W = 32
);
    logic         i_vld;
    logic         o_rdy;
    logic [W-1:0] i_x;
    logic         o_vld;
    logic         i_rdy;
    logic [W-1:0] o_z;

    modport master (
        output i_vld, i_x, i_rdy,
        input  o_rdy, o_vld, o_z
    );

    modport slave (
        input  i_vld, i_x, i_rdy,
        output o_rdy, o_vld, o_z
    );
endinterface

// File: rtl/lix_pipe_stage.sv
// One elastic stage: valid bit plus data word, with load enable and clear.
module lix_pipe_stage
    import lix_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    logic         vld_d;
    logic         vld_q;
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Data only moves with a valid beat; a bubble leaves the old word behind.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (ld_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/lix_pipe.sv
// D-stage elastic pipeline with bubble collapsing, global stall, flush and occupancy count.
module lix_pipe
    import lix_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned D = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_en,
    input  logic                       i_flush,
    lix_pipe_if.slave                  bus,
    output logic [lix_cnt_w(D)-1:0]    o_cnt
);

    localparam int unsigned CW = lix_cnt_w(D);

    logic [D-1:0] vld;
    logic [W-1:0] data [D];
    logic [D-1:0] take;
    logic [CW-1:0] cnt;

    for (genvar g = 0; g < int'(D); g++) begin : g_stage
        logic         ld;
        logic         vld_in;
        logic [W-1:0] data_in;

        // Stage g can accept when any stage from g to the output has room,
        // or the downstream is taking the head beat.
        assign take[g] = bus.i_rdy | ~(&vld[D-1:g]);
        assign ld      = i_en & ~i_flush & take[g];

        if (g == 0) begin : g_head
            assign vld_in  = bus.i_vld;
            assign data_in = bus.i_x;
        end else begin : g_body
            assign vld_in  = vld[g-1];
            assign data_in = data[g-1];
        end

        lix_pipe_stage #(
            .W (W)
        ) u_stage (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .clr_i  (i_flush),
            .ld_i   (ld),
            .vld_i  (vld_in),
            .data_i (data_in),
            .vld_o  (vld[g]),
            .data_o (data[g])
        );
    end

    // Occupancy is the popcount of the registered valid bits.
    always_comb begin
        cnt = '0;
        for (int unsigned k = 0; k < D; k++) begin
            cnt = cnt + CW'(vld[k]);
        end
    end

    assign o_cnt     = cnt;
    assign bus.o_rdy = i_en & ~i_flush & ~rst_i & take[0];
    assign bus.o_vld = i_en & vld[D-1];
    assign bus.o_z   = data[D-1];

endmodule

// File: tb/tb_lix_pipe.sv
// Directed self-checking bench for lix_pipe with W=8, D=3.
module tb_lix_pipe;
    import lix_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 3;
    localparam int unsigned CW = lix_cnt_w(D);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic [CW-1:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;

    lix_pipe_if #(.W(W)) bus ();

    lix_pipe #(
        .W (W),
        .D (D)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .i_en    (en),
        .i_flush (flush),
        .bus     (bus.slave),
        .o_cnt   (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic f, input logic v,
                         input logic [W-1:0] x, input logic r);
        en        = e;
        flush     = f;
        bus.i_vld = v;
        bus.i_x   = x;
        bus.i_rdy = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] s_in  [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
    int           s_cnt [7] = '{1, 2, 3, 3, 2, 1, 0};
    logic         s_v   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] s_z   [7] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};

    initial begin
        int peak;

        // Reset then idle
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        check("rst_rdy", 32'(bus.o_rdy), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_vld", 32'(bus.o_vld), 32'd0);
        check("idle_z",   32'(bus.o_z),   32'h00);
        check("idle_cnt", 32'(cnt),       32'd0);
        check("idle_rdy", 32'(bus.o_rdy), 32'd1);

        // Streaming, one beat per cycle
        peak = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, (i < 4), s_in[i], 1'b1);
            tick();
            if (int'(cnt) > peak) peak = int'(cnt);
            check("str_cnt", 32'(cnt),       32'(s_cnt[i]));
            check("str_vld", 32'(bus.o_vld), 32'(s_v[i]));
            if (s_v[i]) check("str_z", 32'(bus.o_z), 32'(s_z[i]));
        end
        check("str_peak", 32'(peak), 32'd3);

        // Backpressure with a bubble that collapses
        drive(1'b1, 1'b0, 1'b1, 8'hA1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hA2, 1'b0);
        tick();
        check("bp_cnt2", 32'(cnt), 32'd2);
        drive(1'b1, 1'b0, 1'b1, 8'hA3, 1'b0);
        check("bp_rdy_bubble", 32'(bus.o_rdy), 32'd1);
        tick();
        check("bp_cnt3", 32'(cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'hBB, 1'b0);
            check("bp_full_rdy", 32'(bus.o_rdy), 32'd0);
            check("bp_full_vld", 32'(bus.o_vld), 32'd1);
            check("bp_full_z",   32'(bus.o_z),   32'hA1);
            tick();
            check("bp_full_cnt", 32'(cnt), 32'd3);
        end
        drive(1'b1, 1'b0, 1'b1, 8'hB1, 1'b1);
        check("rel_rdy", 32'(bus.o_rdy), 32'd1);
        tick();
        check("rel_cnt_a", 32'(cnt),     32'd3);
        check("rel_z_a2",  32'(bus.o_z), 32'hA2);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check("rel_z_a3",  32'(bus.o_z), 32'hA3);
        check("rel_cnt_b", 32'(cnt),     32'd2);
        tick();
        check("rel_z_b1",  32'(bus.o_z), 32'hB1);
        check("rel_cnt_c", 32'(cnt),     32'd1);
        tick();
        check("rel_vld_e", 32'(bus.o_vld), 32'd0);
        check("rel_cnt_e", 32'(cnt),       32'd0);

        // Global stall with two beats in flight
        drive(1'b1, 1'b0, 1'b1, 8'hC1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hC2, 1'b1);
        tick();
        check("st_cnt0", 32'(cnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
            check("st_vld", 32'(bus.o_vld), 32'd0);
            check("st_rdy", 32'(bus.o_rdy), 32'd0);
            tick();
            check("st_cnt", 32'(cnt), 32'd2);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check("st_out_vld", 32'(bus.o_vld), 32'd1);
        check("st_out_c1",  32'(bus.o_z),   32'hC1);
        check("st_out_cnt", 32'(cnt),       32'd2);
        tick();
        check("st_out_c2",  32'(bus.o_z),   32'hC2);
        check("st_cnt1",    32'(cnt),       32'd1);
        tick();
        check("st_cnt_e",   32'(cnt),       32'd0);

        // Flush with a simultaneous input beat
        drive(1'b1, 1'b0, 1'b1, 8'hD1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hD2, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hD3, 1'b0);
        tick();
        check("fl_cnt_full", 32'(cnt), 32'd3);
        drive(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
        check("fl_rdy", 32'(bus.o_rdy), 32'd0);
        tick();
        check("fl_cnt",   32'(cnt),       32'd0);
        check("fl_stale", 32'(bus.o_z),   32'hD1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("fl_no55", 32'(bus.o_vld), 32'd0);
            tick();
        end

        // Reset mid-stream, then latency of the next beat
        drive(1'b1, 1'b0, 1'b1, 8'hE1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hE2, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hE3, 1'b0);
        tick();
        check("rm_cnt_full", 32'(cnt), 32'd3);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rm_rdy", 32'(bus.o_rdy), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rm_cnt", 32'(cnt),       32'd0);
        check("rm_z",   32'(bus.o_z),   32'h00);
        check("rm_vld", 32'(bus.o_vld), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 8'h66, 1'b1);
        check("rm_rdy_after", 32'(bus.o_rdy), 32'd1);
        tick();
        check("lat_vld1", 32'(bus.o_vld), 32'd0);
        check("lat_cnt1", 32'(cnt),       32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check("lat_vld2", 32'(bus.o_vld), 32'd0);
        tick();
        check("lat_vld3", 32'(bus.o_vld), 32'd1);
        check("lat_z",    32'(bus.o_z),   32'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
